// File: rtl/mem_access_unit_if.sv
// Load/store bus between the pipeline memory stage, mem_access_unit and the word-addressed data memory.
// The slave modport is the unit's view; the master modport is the pipeline-plus-memory side.
interface mem_access_unit_if;
  logic        MREQ;
  logic        MWE;
  logic [1:0]  MSIZE;
  logic        MUNS;
  logic [31:0] MADDR;
  logic [31:0] MWD;
  logic [31:0] MRD;
  logic        STALL;
  logic        MERR;
  logic [31:0] DMA;
  logic [31:0] DMWD;
  logic        DMWE;
  logic [31:0] DMRD;

  modport slave (
    input  MREQ, MWE, MSIZE, MUNS, MADDR, MWD, DMRD,
    output MRD, STALL, MERR, DMA, DMWD, DMWE
  );

  modport master (
    output MREQ, MWE, MSIZE, MUNS, MADDR, MWD, DMRD,
    input  MRD, STALL, MERR, DMA, DMWD, DMWE
  );
endinterface

// File: rtl/mem_access_unit.sv
// Byte-addressed load/store front end for a word-addressed data memory; sub-word stores use a 2-cycle RMW.
// Optional macro MAU_MISALIGN_TRAP_EN turns misaligned half/word accesses into suppressed, MERR-flagging errors.
module mem_access_unit #(
  parameter int MEM_WORDS = 400
) (
  input  logic              CLK,
  input  logic              RST,
  mem_access_unit_if.slave  bus
);

  typedef enum logic {S_IDLE, S_WRITE} state_t;

  localparam logic [31:0] MEM_WORDS_U = 32'(MEM_WORDS);

  state_t       state_q, state_d;
  logic         merr_q, merr_d;
  logic [31:0]  rmw_q, rmw_d;
  logic [29:0]  idx_q;
  logic [1:0]   lane_q;
  logic         half_q;
  logic [15:0]  data_q;

  logic [31:0]  word_idx;
  logic         in_range, is_word, is_half, misalign, access_ok;
  logic         req_idle, start_rmw, err;

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] lane,
                                          input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (size)
      2'b00:   r = uns ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] lane,
                                        input logic half, input logic [15:0] d);
    logic [31:0] r;
    r = w;
    if (half) begin
      if (lane[1]) r[31:16] = d;
      else         r[15:0]  = d;
    end else begin
      r[{lane, 3'b000} +: 8] = d[7:0];
    end
    return r;
  endfunction

  assign word_idx = {2'b00, bus.MADDR[31:2]};
  assign in_range = word_idx < MEM_WORDS_U;
  assign is_word  = bus.MSIZE[1];
  assign is_half  = (bus.MSIZE == 2'b01);

`ifdef MAU_MISALIGN_TRAP_EN
  assign misalign = (is_half & bus.MADDR[0]) | (is_word & (bus.MADDR[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign access_ok = in_range & ~misalign;
  assign req_idle  = bus.MREQ & (state_q == S_IDLE);
  assign start_rmw = req_idle & bus.MWE & ~is_word & access_ok;
  assign err       = req_idle & ~access_ok;

  // Request inputs are only decoded in IDLE; WRITE replays the latched sub-word store.
  always_comb begin
    state_d  = state_q;
    merr_d   = merr_q | err;
    rmw_d    = rmw_q;
    bus.DMA  = 32'b0;
    bus.DMWD = bus.MWD;
    bus.DMWE = 1'b0;
    bus.MRD  = 32'b0;
    bus.STALL = 1'b0;
    if (state_q == S_WRITE) begin
      bus.DMA  = {2'b00, idx_q};
      bus.DMWD = merge(rmw_q, lane_q, half_q, data_q);
      bus.DMWE = ~RST;
      state_d  = S_IDLE;
    end else if (bus.MREQ && access_ok) begin
      bus.DMA = word_idx;
      if (bus.MWE) begin
        if (is_word) begin
          bus.DMWE = ~RST;
        end else begin
          bus.STALL = ~RST;
          rmw_d     = bus.DMRD;
          state_d   = S_WRITE;
        end
      end else begin
        bus.MRD = extract(bus.DMRD, bus.MADDR[1:0], bus.MSIZE, bus.MUNS);
      end
    end
  end

  assign bus.MERR = merr_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      merr_q  <= 1'b0;
      rmw_q   <= 32'b0;
    end else begin
      state_q <= state_d;
      merr_q  <= merr_d;
      rmw_q   <= rmw_d;
    end
  end

  // Store target captured alongside the read half of the RMW.
  always_ff @(posedge CLK) begin
    if (start_rmw) begin
      idx_q  <= bus.MADDR[31:2];
      lane_q <= bus.MADDR[1:0];
      half_q <= is_half;
      data_q <= bus.MWD[15:0];
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: driver queues hand-computed expectations, a negedge monitor checks them.
module tb_mem_access_unit;

  localparam logic [5:0] C_MRD = 6'h01, C_STALL = 6'h02, C_DMWE = 6'h04,
                         C_DMA = 6'h08, C_DMWD = 6'h10, C_MERR = 6'h20;

  typedef struct {
    string       name;
    logic [5:0]  chk;
    logic [31:0] mrd;
    logic        stall;
    logic        dmwe;
    logic [31:0] dma;
    logic [31:0] dmwd;
    logic        merr;
  } exp_t;

  logic CLK;
  logic RST;
  logic mem_init;
  logic merr_exp;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb_q[$];

  logic [31:0] mem [0:399];

  mem_access_unit_if bus ();

  mem_access_unit #(.MEM_WORDS(400)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  assign bus.DMRD = (bus.DMA < 32'd400) ? mem[bus.DMA[8:0]] : 32'b0;

  always @(posedge CLK) begin
    if (mem_init) begin
      for (int i = 0; i < 400; i++) mem[i] <= 32'b0;
      mem[0] <= 32'd17;
      mem[1] <= 32'd31;
      mem[2] <= 32'hFFFF_FFFB;
    end else if (bus.DMWE && bus.DMA < 32'd400) begin
      mem[bus.DMA[8:0]] <= bus.DMWD;
    end
  end

  task automatic push(input string name, input logic [5:0] chk, input logic [31:0] mrd,
                      input logic stall, input logic dmwe, input logic [31:0] dma,
                      input logic [31:0] dmwd, input logic merr);
    exp_t e;
    e.name = name; e.chk = chk; e.mrd = mrd; e.stall = stall;
    e.dmwe = dmwe; e.dma = dma; e.dmwd = dmwd; e.merr = merr;
    sb_q.push_back(e);
  endtask

  task automatic cmp(input string name, input string fld, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s %s: got %h, expected %h", name, fld, act, exp);
    end
  endtask

  task automatic drive(input logic req, input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd);
    bus.MREQ = req; bus.MWE = we; bus.MSIZE = size; bus.MUNS = uns;
    bus.MADDR = addr; bus.MWD = wd;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        if (e.chk[0]) cmp(e.name, "MRD",   bus.MRD,           e.mrd);
        if (e.chk[1]) cmp(e.name, "STALL", {31'b0, bus.STALL}, {31'b0, e.stall});
        if (e.chk[2]) cmp(e.name, "DMWE",  {31'b0, bus.DMWE},  {31'b0, e.dmwe});
        if (e.chk[3]) cmp(e.name, "DMA",   bus.DMA,           e.dma);
        if (e.chk[4]) cmp(e.name, "DMWD",  bus.DMWD,          e.dmwd);
        if (e.chk[5]) cmp(e.name, "MERR",  {31'b0, bus.MERR},  {31'b0, e.merr});
      end
    end
  end

  initial begin
    RST = 1'b1;
    mem_init = 1'b1;
    merr_exp = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    #2;
    push("reset", C_MRD | C_STALL | C_DMWE | C_MERR, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    step();
    step();
    RST = 1'b0;
    mem_init = 1'b0;

    drive(1'b1, 1'b0, 2'b00, 1'b0, 32'd8, 32'd0);
    push("LB8", C_MRD | C_STALL | C_DMWE | C_DMA | C_MERR, 32'hFFFF_FFFB, 1'b0, 1'b0, 32'd2, 32'd0, 1'b0);
    step();
    drive(1'b1, 1'b0, 2'b00, 1'b1, 32'd8, 32'd0);
    push("LBU8", C_MRD | C_STALL, 32'h0000_00FB, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    step();
    drive(1'b1, 1'b0, 2'b01, 1'b0, 32'd10, 32'd0);
    push("LH10", C_MRD | C_STALL, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    step();
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'd4, 32'd0);
    push("LW4", C_MRD | C_STALL | C_DMA, 32'd31, 1'b0, 1'b0, 32'd1, 32'd0, 1'b0);
    step();

    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'd6, 32'd0);
`ifdef MAU_MISALIGN_TRAP_EN
    push("LW6", C_MRD | C_STALL | C_MERR, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    merr_exp = 1'b1;
`else
    push("LW6", C_MRD | C_STALL | C_MERR, 32'd31, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
`endif
    step();
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    push("idle_after_LW6", C_MRD | C_DMWE | C_MERR, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, merr_exp);
    step();

    drive(1'b1, 1'b1, 2'b00, 1'b0, 32'd5, 32'h0000_00AB);
    push("SB5_c0", C_STALL | C_DMWE | C_MERR, 32'd0, 1'b1, 1'b0, 32'd0, 32'd0, merr_exp);
    step();
    push("SB5_c1", C_STALL | C_DMWE | C_DMA | C_DMWD, 32'd0, 1'b0, 1'b1, 32'd1, 32'h0000_AB1F, 1'b0);
    step();
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'd4, 32'd0);
    push("LW4_after_SB", C_MRD | C_STALL, 32'h0000_AB1F, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    step();

    drive(1'b1, 1'b1, 2'b10, 1'b0, 32'd16, 32'h1234_5678);
    push("SW16", C_STALL | C_DMWE | C_DMA | C_DMWD, 32'd0, 1'b0, 1'b1, 32'd4, 32'h1234_5678, 1'b0);
    step();
    drive(1'b1, 1'b0, 2'b01, 1'b1, 32'd18, 32'd0);
    push("LHU18", C_MRD | C_STALL, 32'h0000_1234, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    step();
    drive(1'b1, 1'b0, 2'b00, 1'b0, 32'd16, 32'd0);
    push("LB16", C_MRD, 32'h0000_0078, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    step();

    drive(1'b1, 1'b1, 2'b10, 1'b0, 32'd1600, 32'hDEAD_BEEF);
    push("SW1600", C_STALL | C_DMWE | C_DMA | C_MERR, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, merr_exp);
    step();
    merr_exp = 1'b1;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    push("oor_merr", C_MRD | C_DMWE | C_MERR, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    step();
    push("oor_merr_hold", C_MERR, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    step();
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'd4, 32'd0);
    push("LW4_with_merr", C_MRD | C_MERR, 32'h0000_AB1F, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    step();

    drive(1'b1, 1'b1, 2'b01, 1'b0, 32'd0, 32'h0000_BEEF);
    push("SH0_c0", C_STALL | C_DMWE | C_MERR, 32'd0, 1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
    step();
    #2;
    RST = 1'b1;
    push("SH0_rst_write", C_STALL | C_DMWE | C_MERR, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    step();
    RST = 1'b0;
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'd0, 32'd0);
    push("LW0_after_rst", C_MRD | C_STALL | C_MERR, 32'd17, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    step();
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    push("idle_end", C_MRD | C_DMWE | C_MERR, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    step();

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge CLK);
    if (sb_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending, expected 0", sb_q.size());
    end
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage load/store unit that sits directly upstream of the word-addressed data memory. It converts the pipeline's byte-addressed LB/LBU/LH/LHU/LW/SB/SH/SW requests into word accesses, and performs sub-word stores as a two-cycle read-modify-write with a pipeline stall. It also extracts and extends sub-word load data, and flags out-of-range and misaligned accesses.

## Interface

Parameters:
- MEM_WORDS, default 400: number of 32-bit words in the attached data memory. Legal word indices are 0..MEM_WORDS-1.

Ports:
- CLK  in  1  clock; all state updates on its rising edge.
- RST  in  1  asynchronous, active-high reset.
- MREQ  in  1  a memory operation is valid this cycle.
- MWE  in  1  1 = store, 0 = load.
- MSIZE  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- MUNS  in  1  zero-extend sub-word loads (LBU/LHU).
- MADDR  in  32  byte address.
- MWD  in  32  store data; low byte or low half is used for sub-word stores.
- MRD  out  32  load data, extended to 32 bits.
- STALL  out  1  hold the pipeline; the request inputs must stay stable while STALL is high.
- MERR  out  1  sticky access-error flag.
- DMA  out  32  word index to the data memory.
- DMWD  out  32  write data to the data memory.
- DMWE  out  1  write enable to the data memory.
- DMRD  in  32  combinational read data from the data memory.

## Operation

- Word index is MADDR[31:2]. Byte lane is MADDR[1:0], little-endian. Half lane is MADDR[1].
- Range check:
  - If MADDR[31:2] >= MEM_WORDS, the access is out of range.
  - DMA is driven to 0 on an out-of-range access.
  - The store is suppressed and MRD is 0.
  - MERR is set at the next edge.
- Loads:
  - Complete in the request cycle; there is no stall.
  - The selected byte or half is sign-extended, or zero-extended when MUNS=1.
  - A word load passes DMRD through unchanged.
- Word store: DMWE=1 in the request cycle, DMWD=MWD, no stall.
- Sub-word store uses a two-state FSM:
  - IDLE: on MREQ & MWE & sub-word & in-range, raise STALL. DMWE stays 0. Latch the word index, lane, size and data, and latch DMRD into rmw_q. Next state is WRITE.
  - WRITE: DMA = latched index. DMWD = rmw_q with the target byte or half replaced by the latched data. DMWE=1, STALL=0. Request inputs are ignored. Next state is IDLE.
- Back-to-back sub-word stores take 2 cycles each.
- A load presented after WRITE sees the updated word.
- When MREQ=0, DMWE=0 and MRD=0.

## Timing

- Reset values (asynchronous): state IDLE, STALL=0, MERR=0, rmw_q=0. While RST is high, DMWE=0.
- Latency:
  - Loads and word stores: 0 extra cycles.
  - Sub-word stores: 1 stall cycle, with the write at the end of the second cycle.
- Reset mid-RMW: RST high during WRITE drops the write (DMWE forced 0). The FSM returns to IDLE and STALL=0.
- MERR stays at 1 once set; only RST clears it.
- MERR sets on the rising edge after the offending request. A simultaneous valid access in the same cycle proceeds normally.

## Configuration

- MAU_MISALIGN_TRAP_EN:
  - Defined: a half access with MADDR[0]=1, or a word access with MADDR[1:0]!=0, is misaligned. Its store is suppressed (no stall, DMWE=0), its load returns MRD=0, and MERR sets.
  - Undefined: the ignored low address bits are treated as 0 (aligned down), and misalignment never sets MERR.

## Test plan

- Memory preloaded with word0=17, word1=31, word2=0xFFFFFFFB.
  - LB 8 -> MRD=0xFFFFFFFB.
  - LBU 8 -> 0x000000FB.
  - LH 10 -> 0xFFFFFFFF.
  - LW 4 -> 31.
  - STALL stays 0 throughout.
- SB addr 5, data 0xAB:
  - Cycle 0: STALL=1, DMWE=0.
  - Cycle 1: DMA=1, DMWD=0x0000AB1F, DMWE=1.
  - Then LW 4 -> 0x0000AB1F.
- SW addr 16, data 0x12345678:
  - DMWE=1 in the same cycle, no stall.
  - Then LHU 18 -> 0x00001234 and LB 16 -> 0x00000078.
- LW addr 6:
  - With MAU_MISALIGN_TRAP_EN: MRD=0 and MERR=1 after the edge.
  - Without it: MRD=31 and MERR stays 0.
- SW addr 1600 (word 400), MEM_WORDS=400: DMWE=0, DMA=0, MERR=1 after the edge. MERR persists until RST.
- SH addr 0, data 0xBEEF, with RST pulsed during the WRITE cycle before its rising edge:
  - DMWE=0 and STALL=0.
  - A subsequent LW 0 -> 17.
